mprjram_arbiter: RTL and testbench
==================================

// Module: mprjram_arbiter
// PURPOSE
//  Shares the single-port user-project BRAM (mprjram, CPU window 0x3800_0000) between
//   N_REQ requesters: the Wishbone CPU path (port 0) and the hardware engines
//   (FIR, matmul, qsort DMA).
//  Round-robin arbitration, one BRAM access per cycle.
//  Optional bounded burst lock. Read data returns to its owner after READ_LAT cycles.
// PARAMETERS
//  N_REQ     3   number of requesters; port 0 is the Wishbone/CPU port
//  ADDR_W    10  BRAM word-address width (1024 x 32b)
//  DATA_W    32  data width; strobe width is DATA_W/8
//  READ_LAT  1   BRAM read latency, cycles from bram_en to valid bram_rdata (1..4)
//  LOCK_MAX  16  max consecutive grants one locked requester may hold (>=1)
// PORTS
//  wb_clk_i    in   1              clock
//  wb_rst_n    in   1              synchronous reset, active low
//  req_i       in   N_REQ          access request per requester, held until granted
//  lock_i      in   N_REQ          requester wants to keep ownership after this grant
//  we_i        in   N_REQ*DATA_W/8 per-requester byte write strobes (all 0 = read)
//  addr_i      in   N_REQ*ADDR_W   per-requester word address
//  wdata_i     in   N_REQ*DATA_W   per-requester write data
//  gnt_o       out  N_REQ          one-hot; access of that requester issued this cycle
//  rvalid_o    out  N_REQ          one-hot; read data for that requester valid this cycle
//  rdata_o     out  DATA_W         read data (shared bus; qualify with rvalid_o)
//  bram_en     out  1              BRAM enable
//  bram_we     out  DATA_W/8       BRAM byte write enables
//  bram_addr   out  ADDR_W         BRAM address
//  bram_wdata  out  DATA_W         BRAM write data
//  bram_rdata  in   DATA_W         BRAM read data
//  lock_abort  out  1              pulse: a lock was force-released at LOCK_MAX
// BEHAVIOUR
//  Reset state:
//   - gnt_o, rvalid_o, bram_en, bram_we, lock_abort = 0; rdata_o = 0.
//   - rr_ptr = 0; state = ARB; lock_cnt = 0.
//   - Read-tag pipeline is cleared.
//  Grant timing:
//   - gnt_o is combinational from req_i and registered state.
//   - The BRAM request (en/we/addr/wdata) is driven in the same cycle from the granted port's inputs.
//   - Zero added latency, at most one grant per cycle.
//  Arbitration:
//   - ARB: grant the first requester with req_i set, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - After a grant to k, rr_ptr <= k+1 mod N_REQ. No req_i set: no grant, bram_en = 0.
//  States:
//   - ARB -> LOCKED: the granted requester k has lock_i[k]=1. Record owner=k; lock_cnt <= 1.
//   - LOCKED: only the owner may be granted; other requests wait.
//     Each owner grant increments lock_cnt.
//     Owner idle (req=0, lock=1) keeps the lock with no grant, and lock_cnt does not advance.
//   - LOCKED -> ARB when either:
//     (a) an owner grant with lock_i=0, or
//     (b) lock_i[owner] deasserts while the owner is idle, or
//     (c) lock_cnt reaches LOCK_MAX; pulse lock_abort for one cycle.
//     In all cases rr_ptr <= owner+1.
//  Read return:
//   - A read grant to k (we=0) pushes tag k into a READ_LAT-deep shift pipe.
//   - rvalid_o[k]=1 and rdata_o=bram_rdata exactly READ_LAT cycles later.
//   - Writes push a null tag and produce no rvalid.
//  Boundaries:
//   - Back-to-back reads from different ports return in issue order, one per cycle.
//   - A request deasserted before grant is dropped silently (no gnt).
//   - Reset mid-operation: outstanding read tags are discarded; no rvalid after reset release.
//  Addresses pass through unchanged; there is no bounds check. Requesters keep within 2^ADDR_W words.
// CONFIGURATION
//  MPRJRAM_ARB_CPU_PRIO_EN defined:
//   - In ARB, req_i[0] (CPU) wins over round-robin whenever asserted.
//   - The CPU does not preempt LOCKED.
//   - rr_ptr is not advanced by CPU grants.
//  Not defined: pure round-robin as above, with port 0 as an ordinary peer.
// STRUCTURE
//  Package mprjram_pkg holds:
//   - the state enum {ARB, LOCKED};
//   - the tag type (idx + valid bit);
//   - MPRJRAM_ADDR_W and MPRJRAM_DATA_W constants.
//  Sub-module rr_pick: a rotating first-one finder (req vector, ptr -> one-hot, idx, any).
//   It is reused by the future IRQ arbiter. The read-tag pipe stays inline.
// TESTING
//  1. Reset release, no requests -> gnt_o=0, bram_en=0, rvalid_o=0 for 10 cycles.
//  2. Ports 0,1,2 request reads simultaneously, addr 0x010/0x020/0x030, rr_ptr=0 ->
//     grants 0,1,2 on consecutive cycles; rvalid 0,1,2 READ_LAT later, with matching data.
//  3. Port 1 writes 0xDEAD_BEEF to 0x3FF with we=4'hF, then port 2 reads 0x3FF ->
//     rvalid_o[2] with rdata_o=0xDEADBEEF.
//  4. Port 1 locks with 20 continuous reads; ports 0 and 2 requesting ->
//     16 grants to port 1, lock_abort pulse, next grant goes to port 2.
//  5. Reset asserted one cycle after a read grant (READ_LAT=2) ->
//     no rvalid after reset; state ARB; rr_ptr=0.
//  6. With MPRJRAM_ARB_CPU_PRIO_EN, ports 0 and 1 request continuously ->
//     port 0 granted every cycle. Without the macro -> grants alternate 0,1.

Source files
------------

// File: rtl/mprjram_pkg.sv
// Shared types and constants for the user-project BRAM (mprjram) arbiter.
//   arb_state_e : arbiter FSM state (ARB = free round-robin, LOCKED = burst owner)
//   rd_tag_t    : read-return tag carried down the read-latency pipe
//   MPRJRAM_ADDR_W / MPRJRAM_DATA_W : default BRAM geometry (1024 x 32b)
package mprjram_pkg;

  localparam int MPRJRAM_ADDR_W = 10;
  localparam int MPRJRAM_DATA_W = 32;

  // Tag index width covers up to 16 requesters.
  localparam int TAG_IDX_W = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/mprjram_arbiter_rr_pick.sv
// rr_pick: rotating first-one finder.
//   req    : request vector
//   ptr    : index where the search starts (search order ptr, ptr+1, ... mod N)
//   onehot : one-hot of the chosen request (all zero if none)
//   idx    : index of the chosen request
//   any    : at least one request present
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  function automatic int wrap(input int a);
    return a % N;
  endfunction

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[wrap(int'(ptr) + i)]) begin
        any                            = 1'b1;
        idx                            = IDX_W'(wrap(int'(ptr) + i));
        onehot[wrap(int'(ptr) + i)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mprjram_arbiter.sv
// mprjram_arbiter: shares the single-port user-project BRAM between N_REQ
// requesters (port 0 = Wishbone/CPU, others = hardware engines).
//
// Handshake: req_i[k] is a request; it is accepted in the cycle gnt_o[k] is 1.
// The requester holds req_i/we_i/addr_i/wdata_i stable until that cycle; the
// BRAM access is issued in the same cycle (gnt is combinational). Dropping
// req_i before a grant withdraws the request. Reads return on rvalid_o[k]
// with rdata_o exactly READ_LAT cycles after the grant.
//
// Ports:
//   wb_clk_i, wb_rst_n          clock, synchronous active-low reset
//   req_i, lock_i               per-requester request / keep-ownership
//   we_i, addr_i, wdata_i       per-requester packed access fields (port 0 in LSBs)
//   gnt_o, rvalid_o, rdata_o    grant, read-return valid, shared read data
//   bram_en/we/addr/wdata/rdata BRAM interface
//   lock_abort                  one-cycle pulse when a lock is cut at LOCK_MAX
//   dbg_state, dbg_rr_ptr       FSM state and round-robin pointer
//
// Build option: MPRJRAM_ARB_CPU_PRIO_EN gives port 0 absolute priority in ARB
// (no preemption of LOCKED, CPU grants leave rr_ptr untouched).
module mprjram_arbiter
  import mprjram_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int ADDR_W   = MPRJRAM_ADDR_W,
  parameter int DATA_W   = MPRJRAM_DATA_W,
  parameter int READ_LAT = 1,
  parameter int LOCK_MAX = 16,
  parameter int PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          lock_i,
  input  logic [N_REQ*DATA_W/8-1:0] we_i,
  input  logic [N_REQ*ADDR_W-1:0]   addr_i,
  input  logic [N_REQ*DATA_W-1:0]   wdata_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      bram_en,
  output logic [DATA_W/8-1:0]       bram_we,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic [DATA_W-1:0]         bram_wdata,
  input  logic [DATA_W-1:0]         bram_rdata,
  output logic                      lock_abort,
  output arb_state_e                dbg_state,
  output logic [PTR_W-1:0]          dbg_rr_ptr
);

  localparam int SW    = DATA_W / 8;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              abort_d;
  rd_tag_t           pipe_q [READ_LAT];

  logic [N_REQ-1:0]  owner_mask, cand_req, pick_oh;
  logic [PTR_W-1:0]  pick_idx, gnt_idx;
  logic              pick_any, cpu_win, gnt_any;
  rd_tag_t           tail;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] k);
    return (int'(k) == N_REQ - 1) ? '0 : k + PTR_W'(1);
  endfunction

  // While LOCKED only the owner is a candidate.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) owner_mask[k] = (owner_q == PTR_W'(k));
    cand_req = (state_q == LOCKED) ? (req_i & owner_mask) : req_i;
  end

  rr_pick #(.N(N_REQ), .IDX_W(PTR_W)) u_pick (
    .req    (cand_req),
    .ptr    (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Grant and BRAM request; held off during reset so nothing reaches the BRAM.
  always_comb begin
`ifdef MPRJRAM_ARB_CPU_PRIO_EN
    cpu_win = (state_q == ARB) && req_i[0];
`else
    cpu_win = 1'b0;
`endif
    gnt_any    = wb_rst_n && (cpu_win || pick_any);
    gnt_idx    = cpu_win ? '0 : pick_idx;
    gnt_o      = '0;
    if (gnt_any) gnt_o = cpu_win ? N_REQ'(1) : pick_oh;
    bram_en    = gnt_any;
    bram_we    = gnt_any ? we_i[int'(gnt_idx)*SW +: SW] : '0;
    bram_addr  = addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
    bram_wdata = wdata_i[int'(gnt_idx)*DATA_W +: DATA_W];
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    abort_d    = 1'b0;
    case (state_q)
      ARB: begin
        if (gnt_any) begin
          if (!cpu_win) rr_ptr_d = next_idx(gnt_idx);
          if (lock_i[gnt_idx]) begin
            // With LOCK_MAX == 1 the first grant already exhausts the lock.
            if (LOCK_MAX == 1) begin
              abort_d = 1'b1;
            end else begin
              state_d    = LOCKED;
              owner_d    = gnt_idx;
              lock_cnt_d = CNT_W'(1);
            end
          end
        end
      end
      LOCKED: begin
        if (gnt_any) begin
          if (!lock_i[owner_q]) begin
            state_d    = ARB;
            rr_ptr_d   = next_idx(owner_q);
            lock_cnt_d = '0;
          end else if (lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
            state_d    = ARB;
            rr_ptr_d   = next_idx(owner_q);
            lock_cnt_d = '0;
            abort_d    = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end
        end else if (!lock_i[owner_q]) begin
          state_d    = ARB;
          rr_ptr_d   = next_idx(owner_q);
          lock_cnt_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      lock_abort <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      lock_abort <= abort_d;
      // Every cycle pushes a tag; writes and idle cycles push a null tag.
      pipe_q[0].valid <= gnt_any && (bram_we == '0);
      pipe_q[0].idx   <= TAG_IDX_W'(gnt_idx);
      for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    tail = pipe_q[READ_LAT-1];
    for (int k = 0; k < N_REQ; k++)
      rvalid_o[k] = tail.valid && (tail.idx == TAG_IDX_W'(k));
    rdata_o = tail.valid ? bram_rdata : '0;
  end

  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_mprjram_arbiter.sv
module tb_mprjram_arbiter;
  import mprjram_pkg::*;

  localparam int READ_LAT = 2;
`ifdef MPRJRAM_ARB_CPU_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [2:0]  req, lock;
  logic [3:0]  we_a    [3];
  logic [9:0]  addr_a  [3];
  logic [31:0] wdata_a [3];
  logic [11:0] we_i;
  logic [29:0] addr_i;
  logic [95:0] wdata_i;
  logic [2:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o, bram_wdata, bram_rdata;
  logic        bram_en, lock_abort;
  logic [3:0]  bram_we;
  logic [9:0]  bram_addr;
  arb_state_e  dbg_state;
  logic [1:0]  dbg_rr_ptr;

  assign we_i    = {we_a[2], we_a[1], we_a[0]};
  assign addr_i  = {addr_a[2], addr_a[1], addr_a[0]};
  assign wdata_i = {wdata_a[2], wdata_a[1], wdata_a[0]};

  mprjram_arbiter #(.N_REQ(3), .ADDR_W(10), .DATA_W(32), .READ_LAT(READ_LAT), .LOCK_MAX(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n   (rst_n),
    .req_i      (req),
    .lock_i     (lock),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata),
    .lock_abort (lock_abort),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- BRAM model (preloaded with 0xC0DE_0000 | addr) ----------------
  logic [31:0] mem     [1024];
  logic [31:0] rd_pipe [READ_LAT];
  assign bram_rdata = rd_pipe[READ_LAT-1];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      for (int i = 0; i < READ_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      if (bram_en) begin
        for (int b = 0; b < 4; b++)
          if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
        rd_pipe[0] <= mem[bram_addr];
      end
      for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [2:0]  req;
    logic [9:0]  addr [3];
    int          wport;   // port that writes 0xF strobes this cycle, 3 = none
    logic [31:0] wdata;
    logic [2:0]  gnt;
    logic [9:0]  baddr;
    logic [3:0]  bwe;
    logic [2:0]  rvalid;
    logic [31:0] rdata;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t row(input string nm, input logic [2:0] r,
                               input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                               input int wp, input logic [31:0] wd, input logic [2:0] g,
                               input logic [9:0] ba, input logic [3:0] bw,
                               input logic [2:0] rv, input logic [31:0] rd);
    vec_t v;
    v.name = nm; v.req = r; v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    v.wport = wp; v.wdata = wd; v.gnt = g; v.baddr = ba; v.bwe = bw;
    v.rvalid = rv; v.rdata = rd;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    req = '0; lock = '0;
    for (int p = 0; p < 3; p++) begin
      we_a[p] = '0; addr_a[p] = '0; wdata_a[p] = '0;
    end
  endtask

  task automatic drive_row(input vec_t v);
    req  = v.req;
    lock = '0;
    for (int p = 0; p < 3; p++) begin
      addr_a[p]  = v.addr[p];
      we_a[p]    = (p == v.wport) ? 4'hF : 4'h0;
      wdata_a[p] = (p == v.wport) ? v.wdata : 32'h0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);

    // Reset state.
    @(negedge clk); #1;
    chk("rst_gnt",    32'(gnt_o), 0);
    chk("rst_rvalid", 32'(rvalid_o), 0);
    chk("rst_rdata",  rdata_o, 0);
    chk("rst_abort",  32'(lock_abort), 0);
    chk("rst_en",     32'(bram_en), 0);
    chk("rst_state",  32'(dbg_state), 32'(ARB));
    chk("rst_rrptr",  32'(dbg_rr_ptr), 0);

    // Test 1: release, no requests for 10 cycles.
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("idle_gnt",    32'(gnt_o), 0);
      chk("idle_en",     32'(bram_en), 0);
      chk("idle_rvalid", 32'(rvalid_o), 0);
    end

    // Tests 2/3 and round-robin rotation, one row per cycle (READ_LAT = 2).
    tab.push_back(row("rd3_p0",    3'b111, 10'h010, 10'h020, 10'h030, 3, 32'h0, 3'b001, 10'h010, 4'h0, 3'b000, 32'h0));
    tab.push_back(row("rd3_p1",    3'b110, 10'h010, 10'h020, 10'h030, 3, 32'h0, 3'b010, 10'h020, 4'h0, 3'b000, 32'h0));
    tab.push_back(row("rd3_p2",    3'b100, 10'h010, 10'h020, 10'h030, 3, 32'h0, 3'b100, 10'h030, 4'h0, 3'b001, 32'hC0DE_0010));
    tab.push_back(row("wr_p1",     3'b010, 10'h000, 10'h3FF, 10'h000, 1, 32'hDEAD_BEEF, 3'b010, 10'h3FF, 4'hF, 3'b010, 32'hC0DE_0020));
    tab.push_back(row("rd_p2_3ff", 3'b100, 10'h000, 10'h000, 10'h3FF, 3, 32'h0, 3'b100, 10'h3FF, 4'h0, 3'b100, 32'hC0DE_0030));
    tab.push_back(row("idle_a",    3'b000, 10'h000, 10'h000, 10'h000, 3, 32'h0, 3'b000, 10'h000, 4'h0, 3'b000, 32'h0));
    tab.push_back(row("idle_b",    3'b000, 10'h000, 10'h000, 10'h000, 3, 32'h0, 3'b000, 10'h000, 4'h0, 3'b100, 32'hDEAD_BEEF));
    tab.push_back(row("rr_p0",     3'b011, 10'h100, 10'h101, 10'h000, 3, 32'h0, 3'b001, 10'h100, 4'h0, 3'b000, 32'h0));
    tab.push_back(row("rr_p1",     3'b011, 10'h100, 10'h101, 10'h000, 3, 32'h0, 3'b010, 10'h101, 4'h0, 3'b000, 32'h0));
    tab.push_back(row("rr_p2",     3'b101, 10'h102, 10'h000, 10'h200, 3, 32'h0, 3'b100, 10'h200, 4'h0, 3'b001, 32'hC0DE_0100));
    tab.push_back(row("rr_p0b",    3'b011, 10'h103, 10'h104, 10'h000, 3, 32'h0, 3'b001, 10'h103, 4'h0, 3'b010, 32'hC0DE_0101));
    tab.push_back(row("drain_a",   3'b000, 10'h000, 10'h000, 10'h000, 3, 32'h0, 3'b000, 10'h000, 4'h0, 3'b100, 32'hC0DE_0200));
    tab.push_back(row("drain_b",   3'b000, 10'h000, 10'h000, 10'h000, 3, 32'h0, 3'b000, 10'h000, 4'h0, 3'b001, 32'hC0DE_0103));

    foreach (tab[i]) begin
      @(negedge clk);
      drive_row(tab[i]);
      #1;
      chk({tab[i].name, "_gnt"},    32'(gnt_o),    32'(tab[i].gnt));
      chk({tab[i].name, "_en"},     32'(bram_en),  32'(tab[i].gnt != 3'b000));
      chk({tab[i].name, "_we"},     32'(bram_we),  32'(tab[i].bwe));
      if (tab[i].gnt != 3'b000) chk({tab[i].name, "_addr"}, 32'(bram_addr), 32'(tab[i].baddr));
      if (tab[i].bwe != 4'h0)   chk({tab[i].name, "_wdata"}, bram_wdata, tab[i].wdata);
      chk({tab[i].name, "_rvalid"}, 32'(rvalid_o), 32'(tab[i].rvalid));
      if (tab[i].rvalid != 3'b000) chk({tab[i].name, "_rdata"}, rdata_o, tab[i].rdata);
    end

    // Test 6: ports 0 and 1 request continuously (writes), rr_ptr = 1 here.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clear_inputs();
      req = 3'b011;
      we_a[0] = 4'hF; addr_a[0] = 10'h300; wdata_a[0] = 32'h1111_0000 | 32'(i);
      we_a[1] = 4'hF; addr_a[1] = 10'h301; wdata_a[1] = 32'h2222_0000 | 32'(i);
      #1;
      chk("prio_rr_gnt", 32'(gnt_o), PRIO ? 1 : ((i % 2 == 0) ? 2 : 1));
    end
    idle_cycles(1);
    #1 chk("prio_rr_rvalid", 32'(rvalid_o), 0);

    // Test 4: port 1 locked burst of continuous reads; ports 2 (and 0) waiting.
    // A read issued in iteration i returns in iteration i+2; the scoreboard
    // queue holds the expected data for each locked read in issue order.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      clear_inputs();
      req  = {1'b1, 1'b1, !PRIO};
      lock = 3'b010;
      addr_a[0] = 10'h050;
      addr_a[1] = 10'h040 + 10'(i);
      addr_a[2] = 10'h060;
      #1;
      if (i < 16) begin
        chk("lock_gnt",   32'(gnt_o), 2);
        chk("lock_abort_low", 32'(lock_abort), 0);
        exp_q.push_back(32'hC0DE_0040 + 32'(i));
      end else begin
        chk("lock_abort_pulse", 32'(lock_abort), 1);
        chk("lock_next_gnt",    32'(gnt_o), 4);
        chk("lock_state_arb",   32'(dbg_state), 32'(ARB));
      end
      if (i >= 2) begin
        chk("lock_rvalid", 32'(rvalid_o), 2);
        chk("lock_rdata",  rdata_o, exp_q.pop_front());
      end
    end
    @(negedge clk);
    clear_inputs();
    req  = {1'b0, 1'b1, !PRIO};
    lock = 3'b010;
    addr_a[1] = 10'h070;
    #1;
    chk("after_abort_gnt",  32'(gnt_o), PRIO ? 2 : 1);
    chk("abort_one_cycle",  32'(lock_abort), 0);
    idle_cycles(4);

    // Test 5: reset one cycle after a read grant; the read must not return.
    @(negedge clk);
    clear_inputs();
    req = 3'b100; addr_a[2] = 10'h010;
    #1 chk("pre_rst_gnt", 32'(gnt_o), 4);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    req = 3'b111;
    #1;
    chk("in_rst_gnt",    32'(gnt_o), 0);
    chk("in_rst_en",     32'(bram_en), 0);
    chk("in_rst_rvalid", 32'(rvalid_o), 0);
    chk("in_rst_state",  32'(dbg_state), 32'(ARB));
    chk("in_rst_rrptr",  32'(dbg_rr_ptr), 0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("post_rst_rvalid", 32'(rvalid_o), 0);
    end
    @(negedge clk);
    req = 3'b110;
    #1 chk("post_rst_rr_gnt", 32'(gnt_o), 2);
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
